// File: rtl/mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq_ctrl
// Purpose  : Execute-stage sequencer for the RV32M multiply/divide datapath.
//            Multiplies finish in a single MUL state. DIV/DIVU/REM/REMU use
//            an iterative radix-2 restoring shift-subtract engine. One op is
//            in flight at a time. The result returns to writeback as a tagged
//            valid/ready response. The RISC-V divide-by-zero and
//            signed-overflow result rules are applied on the way out.
// Ports    : clk, rst (sync, active-high), flush (abort in-flight op)
//            req_valid/req_ready/req_op/req_a/req_b/req_tag  - issue side
//            resp_valid/resp_ready/resp_data/resp_tag        - writeback side
//            busy                                            - stall hint
// Config   : Define MDU_EARLY_OUT_EN to let divide-by-zero and signed
//            overflow skip the iteration phase. Results are the same with
//            or without it.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MUL   = 3'd1;
  localparam logic [2:0] ST_DPREP = 3'd2;
  localparam logic [2:0] ST_DITER = 3'd3;
  localparam logic [2:0] ST_DFIX  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]       state, state_nxt;
  logic             not_m;     // op[3]: not an M-extension op, result forced to 0
  logic [1:0]       func_lo;   // func3[1:0]; func3[2] only steers the FSM at accept
  logic [XLEN-1:0]  a_q, b_q;
  logic [XLEN-1:0]  quot, rem, divisor;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;

  // Flush blocks acceptance even when req_ready is high.
  logic accept;
  assign accept = req_valid && req_ready && !flush;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- divide decode ----------------
  // func3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
  logic div_signed, is_rem, div_by_zero, overflow;
  assign div_signed  = !func_lo[0];
  assign is_rem      = func_lo[1];
  assign div_by_zero = (b_q == '0);
  assign overflow    = div_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = (req_op[3] || !req_op[2]) ? ST_MUL : ST_DPREP;
      ST_MUL:   state_nxt = ST_DONE;
`ifdef MDU_EARLY_OUT_EN
      ST_DPREP: state_nxt = (div_by_zero || overflow) ? ST_DFIX : ST_DITER;
`else
      ST_DPREP: state_nxt = ST_DITER;
`endif
      ST_DITER: if (cnt == CNT_W'(XLEN-1)) state_nxt = ST_DFIX;
      ST_DFIX:  state_nxt = ST_DONE;
      ST_DONE:  if (resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // ---------------- output logic ----------------
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_DONE);
    busy       = (state != ST_IDLE);
  end

  // ---------------- multiply ----------------
  // Operands are widened to 2*XLEN with a per-op sign fill, so one signed
  // multiplier covers MUL/MULH/MULHSU/MULHU.
  logic                   a_sx, b_sx;
  logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]        mul_result;
  always_comb begin
    a_sx  = (func_lo == 2'b01 || func_lo == 2'b10) && a_q[XLEN-1];
    b_sx  = (func_lo == 2'b01) && b_q[XLEN-1];
    mul_a = signed'({{XLEN{a_sx}}, a_q});
    mul_b = signed'({{XLEN{b_sx}}, b_q});
    prod  = mul_a * mul_b;
    if (not_m)                 mul_result = '0;
    else if (func_lo == 2'b00) mul_result = prod[XLEN-1:0];
    else                       mul_result = prod[2*XLEN-1:XLEN];
  end

  // ---------------- divide step / fix-up ----------------
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] a_mag, b_mag, div_result;
  always_comb begin
    a_mag   = (div_signed && a_q[XLEN-1]) ? (~a_q + 1'b1) : a_q;
    b_mag   = (div_signed && b_q[XLEN-1]) ? (~b_q + 1'b1) : b_q;
    // Restoring step: bring the next dividend bit into the partial remainder
    // and keep the subtraction only if it did not borrow.
    shifted = {rem, quot[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    // Corner rules override whatever the iteration produced.
    if (div_by_zero)   div_result = is_rem ? a_q : '1;
    else if (overflow) div_result = is_rem ? '0 : a_q;
    else if (is_rem)   div_result = r_neg ? (~rem + 1'b1) : rem;
    else               div_result = q_neg ? (~quot + 1'b1) : quot;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      not_m     <= 1'b0;
      func_lo   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quot      <= '0;
      rem       <= '0;
      divisor   <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            not_m    <= req_op[3];
            func_lo  <= req_op[1:0];
            a_q      <= req_a;
            b_q      <= req_b;
            resp_tag <= req_tag;
          end
        end
        ST_MUL: resp_data <= mul_result;
        ST_DPREP: begin
          quot    <= a_mag;
          divisor <= b_mag;
          rem     <= '0;
          cnt     <= '0;
          q_neg   <= div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
          r_neg   <= div_signed && a_q[XLEN-1];
        end
        ST_DITER: begin
          if (!trial[XLEN]) rem <= trial[XLEN-1:0];
          else              rem <= shifted[XLEN-1:0];
          quot <= {quot[XLEN-2:0], !trial[XLEN]};
          cnt  <= cnt + 1'b1;
        end
        ST_DFIX: resp_data <= div_result;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_seq_ctrl
// Purpose  : Directed scoreboard bench for mdu_seq_ctrl. Each issued op
//            pushes its expected data, tag and latency. The latency counts
//            clock edges with the accept edge as edge 1. The entry is popped
//            when resp_valid appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq_ctrl;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = XLEN + 3;
`ifdef MDU_EARLY_OUT_EN
  localparam int CORNER_LAT = 3;
`else
  localparam int CORNER_LAT = XLEN + 3;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [3:0]       req_op;
  logic [XLEN-1:0]  req_a, req_b, resp_data;
  logic [TAG_W-1:0] req_tag, resp_tag;

  always #5 clk = ~clk;

  mdu_seq_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    int               lat;
    string            name;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic send(input string name, input logic [3:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                      input logic [XLEN-1:0] exp, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    chk({name, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    if (push) begin
      e.data = exp; e.tag = tag; e.lat = lat; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Returns at the negedge where resp_valid is first seen (or budget expires).
  task automatic wait_resp(output int edges, output logic seen);
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   edges;
    logic seen;
    wait_resp(edges, seen);
    e = sb.pop_front();
    chk({e.name, "_resp_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({e.name, "_data"}, 64'(resp_data), 64'(e.data));
      chk({e.name, "_tag"},  64'(resp_tag),  64'(e.tag));
      chk({e.name, "_lat"},  64'(edges),     64'(e.lat));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk({e.name, "_hold_valid"}, 64'(resp_valid), 64'd1);
        chk({e.name, "_hold_data"},  64'(resp_data),  64'(e.data));
        chk({e.name, "_hold_tag"},   64'(resp_tag),   64'(e.tag));
        chk({e.name, "_hold_rdy"},   64'(req_ready),  64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      chk({e.name, "_retired"}, 64'(resp_valid), 64'd0);
      chk({e.name, "_idle"},    64'(req_ready),  64'd1);
    end
  endtask

  initial begin : stim
    int   edges, nresp;
    logic seen;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_resp_data",  64'(resp_data),  64'd0);
    chk("rst_resp_tag",   64'(resp_tag),   64'd0);

    // Multiply family
    send("mul",    4'b0000, 32'h3, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFD, MUL_LAT, 1); collect(0);
    send("mulhu",  4'b0011, 32'h3, 32'hFFFF_FFFF, 5'd7,  32'h0000_0002, MUL_LAT, 1); collect(0);
    send("mulh",   4'b0001, 32'h3, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, MUL_LAT, 1); collect(0);
    send("mulhsu", 4'b0010, 32'h3, 32'hFFFF_FFFF, 5'd4,  32'h0000_0002, MUL_LAT, 1); collect(0);
    send("mulhsn", 4'b0010, 32'hFFFF_FFFF, 32'h3, 5'd5,  32'hFFFF_FFFF, MUL_LAT, 1); collect(0);
    send("notm",   4'b1101, 32'd100, 32'd7,       5'd31, 32'h0,         MUL_LAT, 1); collect(0);

    // Divide family
    send("div",  4'b0100, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, DIV_LAT, 1); collect(0);
    send("rem",  4'b0110, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, DIV_LAT, 1); collect(0);
    send("divu", 4'b0101, 32'd100,       32'd7, 5'd3, 32'd14,        DIV_LAT, 1); collect(0);
    send("remu", 4'b0111, 32'd100,       32'd7, 5'd4, 32'd2,         DIV_LAT, 1); collect(0);

    // Corner rules
    send("div_z",  4'b0100, 32'd5,        32'd0, 5'd10, 32'hFFFF_FFFF, CORNER_LAT, 1); collect(0);
    send("remu_z", 4'b0111, 32'd5,        32'd0, 5'd11, 32'd5,         CORNER_LAT, 1); collect(0);
    send("rem_zn", 4'b0110, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, CORNER_LAT, 1); collect(0);
    send("div_ov", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, CORNER_LAT, 1); collect(0);
    send("rem_ov", 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0,         CORNER_LAT, 1); collect(0);

    // Backpressure: hold the DIVU result for 10 cycles
    send("divu_bp", 4'b0101, 32'd100, 32'd7, 5'd21, 32'd14, DIV_LAT, 1); collect(10);

    // Flush at DITER cycle 10, then a MUL accepted the following cycle
    send("div_fl", 4'b0100, 32'd1000, 32'd3, 5'd9, 32'h0, 0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_idle",  64'(req_ready),  64'd1);
    chk("flush_valid", 64'(resp_valid), 64'd0);
    chk("flush_busy",  64'(busy),       64'd0);
    send("mul_afl", 4'b0000, 32'd6, 32'd7, 5'd17, 32'd42, MUL_LAT, 1); collect(0);

    // Reset held 2 cycles mid-DITER drops the op
    send("div_rst", 4'b0100, 32'd1000, 32'd3, 5'd8, 32'h0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_idle",  64'(req_ready),  64'd1);
    chk("rstmid_valid", 64'(resp_valid), 64'd0);
    chk("rstmid_busy",  64'(busy),       64'd0);
    chk("rstmid_tag",   64'(resp_tag),   64'd0);
    nresp = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("rstmid_noresp", 64'(nresp), 64'd0);

    // Flush in DONE while resp_ready=1: result is discarded, not retired
    send("mul_fd", 4'b0000, 32'd2, 32'd2, 5'd6, 32'h0, 0, 0);
    wait_resp(edges, seen);
    chk("fd_seen", 64'(seen), 64'd1);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; resp_ready = 1'b0;
    chk("fd_valid", 64'(resp_valid), 64'd0);
    chk("fd_idle",  64'(req_ready),  64'd1);

    // Flush with req_valid in IDLE: op not accepted
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0000; req_a = 32'd9; req_b = 32'd9; req_tag = 5'd2;
    flush = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    chk("fi_busy", 64'(busy),      64'd0);
    chk("fi_idle", 64'(req_ready), 64'd1);
    nresp = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("fi_noresp", 64'(nresp), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
